mem_line_arbiter: RTL and testbench

//  N-channel arbiter merging cache-line refill/writeback requests onto one slow-memory port.

---
 rtl/memarb_pkg.sv | 18 +
 rtl/mem_line_arbiter_rr_picker.sv | 31 +++
 rtl/mem_line_arbiter.sv | 118 +++++++++++
 tb/tb_mem_line_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared definitions for the memory line arbiter: line geometry, FSM states and memory op codes.
package memarb_pkg;

  localparam int LINE_AW = 28;
  localparam int LINE_DW = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_line_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
module rr_picker #(
  parameter int NCH = 2,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic           valid
);

  logic found;
  int   idx;

  // Scan starting at ptr and wrapping; the first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mem_line_arbiter.sv
// N-channel round-robin arbiter merging cache-line requests onto one slow-memory port.
// Optional per-channel grant counters are built when MEMARB_PERF_EN is defined.
module mem_line_arbiter
  import memarb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = LINE_AW,
  parameter int DW  = LINE_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    cli_read,
  input  logic [NCH-1:0]    cli_write,
  input  logic [NCH*AW-1:0] cli_addr,
  input  logic [NCH*DW-1:0] cli_wdata,
  output logic [DW-1:0]     cli_rdata,
  output logic [NCH-1:0]    cli_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready,
  output logic [NCH*32-1:0] perf_grant_cnt
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         state_q, state_d;
  op_t            op_q;
  logic [NCH-1:0] req, pick_gnt, grant_q;
  logic           pick_valid;
  logic [PW-1:0]  rr_ptr_q, grant_idx_q, pick_idx;

  assign req = cli_read | cli_write;

  rr_picker #(.NCH(NCH), .PW(PW)) u_picker (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_ready)  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant, op and line payload are latched once in IDLE and held until the transaction retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      op_q        <= OP_RD;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cli_rdata   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q     <= pick_gnt;
            grant_idx_q <= pick_idx;
            op_q        <= cli_write[pick_idx] ? OP_WR : OP_RD;
            mem_addr    <= cli_addr[int'(pick_idx)*AW +: AW];
            mem_wdata   <= cli_wdata[int'(pick_idx)*DW +: DW];
          end
        end
        ST_ISSUE: begin
          if (mem_ready) cli_rdata <= mem_rdata;
        end
        ST_RESP: begin
          rr_ptr_q <= (grant_idx_q == PW'(NCH - 1)) ? '0 : grant_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_read  = (state_q == ST_ISSUE) && (op_q == OP_RD);
  assign mem_write = (state_q == ST_ISSUE) && (op_q == OP_WR);
  assign cli_ready = (state_q == ST_RESP) ? grant_q : '0;

`ifdef MEMARB_PERF_EN
  for (genvar g = 0; g < NCH; g++) begin : g_perf
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (state_q == ST_RESP && grant_q[g] && cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign perf_grant_cnt[g*32 +: 32] = cnt_q;
  end
`else
  assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Randomized self-checking bench for mem_line_arbiter against a queue-free round-robin reference model.
module tb_mem_line_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 28;
  localparam int DW  = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    cli_read = '0, cli_write = '0;
  logic [NCH*AW-1:0] cli_addr = '0;
  logic [NCH*DW-1:0] cli_wdata = '0;
  logic [DW-1:0]     cli_rdata;
  logic [NCH-1:0]    cli_ready;
  logic              mem_read, mem_write;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [NCH*32-1:0] perf_grant_cnt;

  mem_line_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_read(cli_read), .cli_write(cli_write), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
    .cli_rdata(cli_rdata), .cli_ready(cli_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .perf_grant_cnt(perf_grant_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what each client is asking for, the fairness pointer, and grants served.
  bit            pend [NCH];
  bit            p_wr [NCH];
  logic [AW-1:0] p_addr [NCH];
  logic [DW-1:0] p_data [NCH];
  int            m_ptr = 0;
  int            g_cnt [NCH];

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 read, 1 write, 2 read+write (served as a write)
  task automatic applyStimulus(input int ch, input int kind);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom);
    d = {$urandom, $urandom, $urandom, $urandom};
    pend[ch]   = 1'b1;
    p_wr[ch]   = (kind != 0);
    p_addr[ch] = a;
    p_data[ch] = d;
    cli_read[ch]  = (kind != 1);
    cli_write[ch] = (kind != 0);
    cli_addr[ch*AW +: AW]  = a;
    cli_wdata[ch*DW +: DW] = d;
  endtask

  function automatic int anyPending();
    int n = 0;
    for (int c = 0; c < NCH; c++) if (pend[c]) n++;
    return n;
  endfunction

  // Serve one transaction as the memory, starting from a negedge where requests are set up.
  task automatic serveOne(input int exp_wait);
    int exp_ch = -1;
    int waited = 0;
    int lat;
    logic [DW-1:0] rd;
    logic [NCH-1:0] exp_rdy;
    for (int k = 0; k < NCH; k++) begin
      int c = (m_ptr + k) % NCH;
      if (exp_ch < 0 && pend[c]) exp_ch = c;
    end
    if (exp_ch < 0) begin
      checkOutput("model_pending", 0, 1);
      return;
    end
    do begin
      @(negedge clk);
      mem_ready = 1'b0;
      waited++;
    end while (!(mem_read || mem_write) && waited < 8);
    checkOutput("issue_lat", waited, exp_wait);
    if (!(mem_read || mem_write)) return;
    checkOutput("mem_read", mem_read, !p_wr[exp_ch]);
    checkOutput("mem_write", mem_write, p_wr[exp_ch]);
    checkOutput("mem_addr", mem_addr, p_addr[exp_ch]);
    checkOutput("mem_wdata", mem_wdata, p_data[exp_ch]);
    if ($urandom_range(0, 3) == 0) begin
      cli_read[exp_ch]  = 1'b0;
      cli_write[exp_ch] = 1'b0;
    end
    lat = $urandom_range(0, 4);
    repeat (lat) begin
      @(negedge clk);
      checkOutput("mem_hold", {mem_read, mem_write}, {!p_wr[exp_ch], p_wr[exp_ch]});
      checkOutput("addr_hold", mem_addr, p_addr[exp_ch]);
    end
    rd = {$urandom, $urandom, $urandom, $urandom};
    mem_rdata = rd;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    exp_rdy = '0;
    exp_rdy[exp_ch] = 1'b1;
    checkOutput("cli_ready", cli_ready, exp_rdy);
    checkOutput("cli_rdata", cli_rdata, rd);
    checkOutput("mem_idle", {mem_read, mem_write}, 2'b00);
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    pend[exp_ch] = 1'b0;
    cli_read[exp_ch]  = 1'b0;
    cli_write[exp_ch] = 1'b0;
    m_ptr = (exp_ch + 1) % NCH;
    g_cnt[exp_ch]++;
  endtask

  task automatic checkPerf();
    for (int c = 0; c < NCH; c++) begin
`ifdef MEMARB_PERF_EN
      checkOutput("perf_cnt", perf_grant_cnt[c*32 +: 32], g_cnt[c]);
`else
      checkOutput("perf_cnt", perf_grant_cnt[c*32 +: 32], 0);
`endif
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      pend[c] = 1'b0;
      g_cnt[c] = 0;
    end
    #1;
    checkOutput("rst_ready", cli_ready, 0);
    checkOutput("rst_mem", {mem_read, mem_write}, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_rdata", cli_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First transaction from a quiet IDLE, then a mixed random run.
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    serveOne(1);
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c] && (t < 6 || $urandom_range(0, 1) == 1)) applyStimulus(c, $urandom_range(0, 2));
      end
      if (anyPending() == 0) applyStimulus($urandom_range(0, NCH - 1), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) mem_ready = 1'b1;
      serveOne(2);
    end
    while (anyPending() != 0) serveOne(2);
    checkPerf();

    // Reset in the middle of an issued ch1 read; pointer must return to channel 0.
    applyStimulus(0, 0);
    serveOne(2);
    applyStimulus(1, 0);
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_issue", mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_mem", {mem_read, mem_write}, 0);
    checkOutput("mid_rst_ready", cli_ready, 0);
    m_ptr = 0;
    for (int c = 0; c < NCH; c++) g_cnt[c] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 2);
    serveOne(1);
    serveOne(2);
    checkPerf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
